// File: rtl/redmule_castout_ctrl.sv
// redmule_castout_ctrl
//   Sequences one cast-out job: streams cfg_nwords_i words from the Z-buffer
//   side through an external fixed-latency castout unit into a local output
//   FIFO. A word is issued only when a FIFO slot is already reserved for it,
//   because the castout pipeline cannot stall. The per-job cast configuration
//   is latched at start and held until the next job is accepted.
//
//   Ports
//     clk_i, rst_i, clear_i        clock, sync active-high reset, sync soft clear
//     start_i, cfg_*_i             job start pulse and per-job configuration
//     in_valid_i/in_data_i/in_ready_o     source word handshake
//     cast_src_o/cast_en_o/cast_fmt_o     operand and controls to castout unit
//     cast_dst_i                   castout result, CAST_LAT cycles after issue
//     out_valid_o/out_data_o/out_ready_i  FIFO head towards the store streamer
//     busy_o, done_o               job status; done_o pulses once per job
//
//   Optional build macro REDMULE_CASTOUT_CTRL_PERF_EN adds stall_cnt_o and
//   backp_cnt_o saturating performance counters.
module redmule_castout_ctrl #(
    parameter int unsigned DATA_W     = 288,
    parameter int unsigned CAST_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FMT_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic              cfg_cast_i,
    input  logic [FMT_W-1:0]  cfg_dst_fmt_i,
    input  logic [CNT_W-1:0]  cfg_nwords_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] cast_src_o,
    output logic              cast_en_o,
    output logic [FMT_W-1:0]  cast_fmt_o,
    input  logic [DATA_W-1:0] cast_dst_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef REDMULE_CASTOUT_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       backp_cnt_o
`endif
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + CAST_LAT + 1) + 1;
    localparam int unsigned PIPE_W = (CAST_LAT > 0) ? CAST_LAT : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               flush;
    logic               start_acc;
    logic               issue, push, pop;
    logic [CNT_W-1:0]   remaining_q;
    logic [PIPE_W-1:0]  pipe_q;
    logic [OCC_W-1:0]   inflight;
    logic [OCC_W-1:0]   fifo_cnt_q;
    logic [OCC_W-1:0]   cnt_after_pop;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

    assign flush      = rst_i | clear_i;
    assign cast_src_o = in_data_i;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

    assign out_valid_o = (fifo_cnt_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign pop         = out_valid_o & out_ready_i;

    // Words still inside the castout unit already own a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < PIPE_W; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
    end

    // Occupancy after this cycle's pop, so a pop frees its credit immediately.
    assign cnt_after_pop = fifo_cnt_q - OCC_W'(pop);
    assign in_ready_o    = (state_q == RUN) && (remaining_q != '0) &&
                           ((cnt_after_pop + inflight) < OCC_W'(FIFO_DEPTH));
    assign issue         = in_valid_i & in_ready_o;
    assign push          = (CAST_LAT == 0) ? issue : pipe_q[PIPE_W-1];

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = (cfg_nwords_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue && (remaining_q == CNT_W'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_cnt_q == '0)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cast_en_o   <= 1'b0;
            cast_fmt_o  <= '0;
            pipe_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                remaining_q <= cfg_nwords_i;
                cast_en_o   <= cfg_cast_i;
                cast_fmt_o  <= cfg_dst_fmt_i;
            end else if (issue) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
            pipe_q[0] <= (CAST_LAT > 0) & issue;
            for (int unsigned i = 1; i < PIPE_W; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Storage needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem_q[wr_ptr_q] <= cast_dst_i;
    end

`ifdef REDMULE_CASTOUT_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (flush || start_acc) begin
            stall_cnt_o <= '0;
            backp_cnt_o <= '0;
        end else begin
            if ((state_q == RUN) && in_valid_i && !in_ready_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (out_valid_o && !out_ready_i && (backp_cnt_o != '1))
                backp_cnt_o <= backp_cnt_o + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (flush)
        !(push && !pop && (fifo_cnt_q == OCC_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_redmule_castout_ctrl.sv
// Scoreboard bench for redmule_castout_ctrl. Also emulates the external
// castout unit (fixed latency) driven by the DUT's cast controls.
module tb_redmule_castout_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned FW    = 3;

    logic          clk = 1'b0;
    logic          rst, clear, start, cfg_cast;
    logic [FW-1:0] cfg_fmt;
    logic [CW-1:0] cfg_nw;
    logic          in_valid, in_ready, cast_en, out_valid, out_ready, busy, done;
    logic [DW-1:0] in_data, cast_src, cast_dst, out_data;
    logic [FW-1:0] cast_fmt;
`ifdef REDMULE_CASTOUT_CTRL_PERF_EN
    logic [31:0]   stall_cnt, backp_cnt;
`endif

    always #5 clk = ~clk;

    redmule_castout_ctrl #(
        .DATA_W(DW), .CAST_LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .FMT_W(FW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .cfg_cast_i(cfg_cast), .cfg_dst_fmt_i(cfg_fmt), .cfg_nwords_i(cfg_nw),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .cast_src_o(cast_src), .cast_en_o(cast_en), .cast_fmt_o(cast_fmt),
        .cast_dst_i(cast_dst), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_ready_i(out_ready), .busy_o(busy), .done_o(done)
`ifdef REDMULE_CASTOUT_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt), .backp_cnt_o(backp_cnt)
`endif
    );

    // Castout transfer function: enable selects a format-dependent transform.
    function automatic logic [DW-1:0] cast_ref(input logic [DW-1:0] x, input logic en,
                                               input logic [FW-1:0] fmt);
        return en ? ((x * 32'd3 + {29'd0, fmt}) ^ 32'hA5A5_0000) : x;
    endfunction

    // External castout unit: LAT-cycle pipeline fed by the DUT's controls.
    logic [DW-1:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= cast_ref(cast_src, cast_en, cast_fmt);
        for (int i = 1; i < int'(LAT); i++) dl[i] <= dl[i-1];
    end
    assign cast_dst = dl[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    logic [DW-1:0] exp_q [$];
    int job_nw, job_iss, job_out, job_done, first_iss, first_vld, last_out;
    int rdy_seen, vld_seen, m_stall, m_backp;
    logic          job_en;
    logic [FW-1:0] job_fmt;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst || clear) begin
                exp_q.delete();
            end else begin
                if (start && !busy) begin
                    job_iss = 0; job_out = 0; job_done = 0; first_iss = -1;
                    first_vld = -1; last_out = -1; rdy_seen = 0; vld_seen = 0;
                    m_stall = 0; m_backp = 0;
                end else begin
                    if (busy && in_valid && !in_ready && job_iss < job_nw) m_stall++;
                    if (out_valid && !out_ready) m_backp++;
                end
                if (in_ready) rdy_seen++;
                if (out_valid) begin
                    vld_seen++;
                    if (first_vld < 0) first_vld = cyc;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(cast_ref(in_data, job_en, job_fmt));
                    if (first_iss < 0) first_iss = cyc;
                    job_iss++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                    else check("out_data", out_data, exp_q.pop_front());
                    job_out++;
                    last_out = cyc;
                end
                if (done) job_done++;
                if (busy) begin
                    check("cast_fmt", cast_fmt, job_fmt);
                    check("cast_en", cast_en, job_en);
                end
            end
        end
    endtask

    task automatic start_job(input int nw, input logic en, input logic [FW-1:0] fmt);
        job_nw = nw; job_en = en; job_fmt = fmt;
        cfg_nw = CW'(nw); cfg_cast = en; cfg_fmt = fmt;
        in_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; cfg_cast = ~en; cfg_fmt = ~fmt; cfg_nw = CW'(nw + 5);
    endtask

    task automatic finish_job(input int vp, input int rp, input bit seq, input bit poke,
                              input bit rate);
        int budget = 0;
        if (poke) start = 1'b1;
        while (job_done == 0 && budget < 3000) begin
            in_valid  = ($urandom_range(99) < vp);
            in_data   = seq ? DW'(job_iss) : $urandom;
            out_ready = ($urandom_range(99) < rp);
            @(negedge clk); #1;
            budget++;
            if (job_done == 0) tick();
        end
        check("job_timeout", budget < 3000, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_low_after", done, 0);
        check("done_count", job_done, 1);
        check("words_out", job_out, job_nw);
        check("sb_empty", exp_q.size(), 0);
        if (job_nw > 0) begin
            check("first_latency", first_vld - first_iss, LAT + 1);
        end else begin
            check("empty_in_ready", rdy_seen, 0);
            check("empty_out_valid", vld_seen, 0);
        end
        if (rate) check("throughput", last_out - first_vld, job_nw - 1);
        tick();
    endtask

    initial begin
        fork
            monitor();
            begin
                #400000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        rst = 1'b1; clear = 1'b0; start = 1'b0; cfg_cast = 1'b0; cfg_fmt = '0; cfg_nw = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        job_nw = 0; job_en = 1'b0; job_fmt = '0;
        repeat (3) tick();
        @(negedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cast_en", cast_en, 0);
        check("rst_cast_fmt", cast_fmt, 0);
        tick();
        rst = 1'b0;
        tick();

        // Full-rate job, FP16 destination.
        start_job(8, 1'b1, 3'd2);
        finish_job(100, 100, 1'b1, 1'b0, 1'b1);

        // Empty job.
        start_job(0, 1'b1, 3'd1);
        finish_job(50, 50, 1'b0, 1'b0, 1'b0);

        // Sink blocked: credits run out after DEPTH issues.
        start_job(8, 1'b1, 3'd4);
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (13) begin
            in_data = DW'(job_iss);
            tick();
        end
        check("hold_issued", job_iss, DEPTH);
        check("hold_in_ready", in_ready, 0);
        check("hold_out_valid", out_valid, 1);
`ifdef REDMULE_CASTOUT_CTRL_PERF_EN
        check("backp_cnt", backp_cnt, 10);
        check("backp_model", backp_cnt, m_backp);
        check("stall_cnt", stall_cnt, 9);
        check("stall_model", stall_cnt, m_stall);
`endif
        finish_job(100, 100, 1'b1, 1'b0, 1'b0);

        // Random handshakes, start held high throughout.
        start_job(100, 1'b1, 3'd3);
        finish_job(50, 50, 1'b0, 1'b1, 1'b0);
        start_job(20, 1'b0, 3'd1);
        finish_job(50, 70, 1'b0, 1'b0, 1'b0);

        // Clear in DRAIN while both words are inside the castout unit.
        start_job(2, 1'b1, 3'd5);
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 20 && job_iss < 2; k++) begin
            in_data = DW'(job_iss);
            @(negedge clk); #1;
            if (job_iss < 2) tick();
        end
        check("clr_issued", job_iss, 2);
        tick();
        clear = 1'b1; in_valid = 1'b0;
        tick();
        clear = 1'b0;
        @(negedge clk); #1;
        check("clr_busy", busy, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 0);
        check("clr_cast_en", cast_en, 0);
        tick();
        start_job(3, 1'b1, 3'd0);
        finish_job(50, 50, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
